inst_fetch_responder: RTL and testbench

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

---
 rtl/inst_fetch_responder.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: a word array that is loaded through a program-load port
// and then answers single-cycle fetch requests, with stall, flush and error reporting.
module inst_fetch_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic        misalign_err,
  output logic        range_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        misalign_err_q, misalign_err_d;
  logic        range_err_q, range_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic                  ld_fire;
  logic                  ld_we;
  logic                  accept;
  logic                  pc_misaligned;
  logic                  pc_in_range;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  assign ld_ready      = (state_q != RUN);
  assign ld_fire       = ld_valid && ld_ready;
  assign ld_we         = ld_fire && (ld_addr[31:DEPTH_LOG2+2] == '0);
  assign wr_idx        = ld_addr[DEPTH_LOG2+1:2];
  assign rd_idx        = pc[DEPTH_LOG2+1:2];
  assign pc_misaligned = (pc[1:0] != 2'b00);
  assign pc_in_range   = (pc[31:DEPTH_LOG2+2] == '0);
  assign accept        = ce && !stall && !flush && !ld_fire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ld_valid)  state_d = LOAD;
        else if (ce)   state_d = RUN;
      end
      LOAD: begin
        if (!ld_valid) state_d = ce ? RUN : IDLE;
      end
      RUN: begin
        if (!ce)       state_d = IDLE;
      end
      default:         state_d = IDLE;
    endcase
  end

  // Flush outranks stall, stall outranks a new request; idle cycles keep inst_pc.
  always_comb begin
    inst_d         = inst_q;
    inst_valid_d   = inst_valid_q;
    inst_pc_d      = inst_pc_q;
    misalign_err_d = misalign_err_q;
    range_err_d    = range_err_q;
    fetch_count_d  = fetch_count_q;
    if (flush) begin
      inst_d         = NOP_INSN;
      inst_valid_d   = 1'b0;
      inst_pc_d      = '0;
      misalign_err_d = 1'b0;
      range_err_d    = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (accept) begin
      inst_valid_d   = 1'b1;
      inst_pc_d      = pc;
      misalign_err_d = pc_misaligned;
      range_err_d    = !pc_in_range;
      inst_d         = (pc_misaligned || !pc_in_range) ? NOP_INSN : mem[rd_idx];
      if (fetch_count_q != '1) fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      inst_d         = NOP_INSN;
      inst_valid_d   = 1'b0;
      misalign_err_d = 1'b0;
      range_err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      inst_q         <= NOP_INSN;
      inst_valid_q   <= 1'b0;
      inst_pc_q      <= '0;
      misalign_err_q <= 1'b0;
      range_err_q    <= 1'b0;
      fetch_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      inst_q         <= inst_d;
      inst_valid_q   <= inst_valid_d;
      inst_pc_q      <= inst_pc_d;
      misalign_err_q <= misalign_err_d;
      range_err_q    <= range_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  // Array is never reset; the rst_n gate suppresses a write on an edge seen during reset.
  always_ff @(posedge clk) begin
    if (ld_we && rst_n) mem[wr_idx] <= ld_data;
  end

  assign inst         = inst_q;
  assign inst_valid   = inst_valid_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = misalign_err_q;
  assign range_err    = range_err_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed self-checking bench for inst_fetch_responder (default parameters).
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] prog [0:3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};

  inst_fetch_responder #(.DEPTH_LOG2(10), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pc(pc), .stall(stall), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .misalign_err(misalign_err), .range_err(range_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] e_inst, input logic e_valid,
                            input logic [31:0] e_pc, input logic e_mis, input logic e_rng,
                            input logic [31:0] e_cnt);
    check({tag, ".inst"},  inst, e_inst);
    check({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
    check({tag, ".pc"},    inst_pc, e_pc);
    check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, e_mis});
    check({tag, ".rng"},   {31'd0, range_err}, {31'd0, e_rng});
    check({tag, ".cnt"},   fetch_count, e_cnt);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    step(); step();
    check_resp("reset", NOP, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("reset.ld_ready", {31'd0, ld_ready}, 32'd1);
    rst_n = 1'b1;

    // program load
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 32'(i * 4); ld_data = prog[i];
      step();
    end
    check("load.ld_ready", {31'd0, ld_ready}, 32'd1);
    check("load.valid", {31'd0, inst_valid}, 32'd0);
    ld_valid = 1'b0;

    // sequential fetch
    ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      step();
      check_resp("fetch", prog[i], 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'(i + 1));
    end
    check("run.ld_ready", {31'd0, ld_ready}, 32'd0);

    // stall holds the pc=8 response
    pc = 32'd8; step();
    check_resp("pre_stall", 32'h0020_81B3, 1'b1, 32'd8, 1'b0, 1'b0, 32'd5);
    stall = 1'b1; pc = 32'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      check_resp("stall", 32'h0020_81B3, 1'b1, 32'd8, 1'b0, 1'b0, 32'd5);
    end
    stall = 1'b0; step();
    check_resp("resume", 32'h0000_006F, 1'b1, 32'd12, 1'b0, 1'b0, 32'd6);

    // flush beats stall and ce
    flush = 1'b1; stall = 1'b1; pc = 32'd4; step();
    check_resp("flush", NOP, 1'b0, 32'd0, 1'b0, 1'b0, 32'd6);
    flush = 1'b0; stall = 1'b0;

    // error cases
    pc = 32'h0000_0006; step();
    check_resp("misalign", NOP, 1'b1, 32'h6, 1'b1, 1'b0, 32'd7);
    pc = 32'h0000_1000; step();
    check_resp("range", NOP, 1'b1, 32'h1000, 1'b0, 1'b1, 32'd8);
    pc = 32'h0000_1002; step();
    check_resp("both_err", NOP, 1'b1, 32'h1002, 1'b1, 1'b1, 32'd9);

    // load ignored in RUN
    ld_valid = 1'b1; ld_addr = '0; ld_data = 32'hDEAD_BEEF; pc = '0;
    #1;
    check("run_ld.ld_ready", {31'd0, ld_ready}, 32'd0);
    step();
    check_resp("run_ld", 32'h0050_0093, 1'b1, 32'd0, 1'b0, 1'b0, 32'd10);
    ld_valid = 1'b0;

    // RUN -> IDLE, idle bubble keeps inst_pc
    ce = 1'b0; pc = 32'd8; step();
    check_resp("idle", NOP, 1'b0, 32'd0, 1'b0, 1'b0, 32'd10);
    check("idle.ld_ready", {31'd0, ld_ready}, 32'd1);

    // load wins over fetch in IDLE
    ld_valid = 1'b1; ce = 1'b1; ld_addr = 32'h10; ld_data = 32'h1234_5678; pc = '0; step();
    check_resp("ld_win", NOP, 1'b0, 32'd0, 1'b0, 1'b0, 32'd10);
    check("ld_win.ld_ready", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b0; pc = 32'h10; step();
    check_resp("ld_win_rd", 32'h1234_5678, 1'b1, 32'h10, 1'b0, 1'b0, 32'd11);

    // out-of-range load is dropped (would alias mem[0])
    ce = 1'b0; step();
    ld_valid = 1'b1; ld_addr = 32'h0000_1000; ld_data = 32'hBADB_AD00; step();
    ld_valid = 1'b0; ce = 1'b1; pc = '0; step();
    check_resp("ld_drop", 32'h0050_0093, 1'b1, 32'd0, 1'b0, 1'b0, 32'd12);

    // asynchronous reset mid-stream, with a write attempt during reset
    pc = 32'd4; step();
    #2; rst_n = 1'b0; #1;
    check_resp("async_rst", NOP, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("async_rst.ld_ready", {31'd0, ld_ready}, 32'd1);
    ce = 1'b0; ld_valid = 1'b1; ld_addr = '0; ld_data = 32'hFFFF_FFFF;
    step();
    check_resp("in_rst", NOP, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    ld_valid = 1'b0; rst_n = 1'b1;
    ce = 1'b1; pc = '0; step();
    check_resp("post_rst", 32'h0050_0093, 1'b1, 32'd0, 1'b0, 1'b0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
